// File: rtl/ball_animator.sv
// Ball sprite motion controller.
// On each frame it erases the previous box, steps the ball physics, and redraws the box.
// It handshakes with the downstream box drawer through go and box_done.
//
// state      | meaning
// IDLE       | waiting for a frame tick (or a pending one) or a launch
// ERASE_REQ  | erase request issued (go high this cycle, background colour)
// ERASE_WAIT | waiting for the drawer to finish the erase
// UPDATE     | one-cycle physics step; draw request set up at exit
// DRAW_REQ   | draw request issued (go high this cycle, ball colour)
// DRAW_WAIT  | waiting for the drawer to finish the draw
module ball_animator #(
  parameter int unsigned X0       = 10,
  parameter int unsigned Y0       = 100,
  parameter int unsigned SIZE     = 4,
  parameter logic [2:0]  BALL_CLR = 3'b110,
  parameter logic [2:0]  BG_CLR   = 3'b000,
  parameter int unsigned XMAX     = 160,
  parameter int unsigned FLOOR    = 120,
  parameter int unsigned GRAV_DIV = 2,
  parameter int unsigned VMAX     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [4:0] launch_vx,
  input  logic [4:0] launch_vy,
  input  logic       box_done,
  output logic [7:0] Xout,
  output logic [6:0] Yout,
  output logic [2:0] CLRout,
  output logic [5:0] Scaleout,
  output logic       go,
  output logic       busy,
  output logic       in_flight,
  output logic       landed
);

  localparam logic signed [9:0] X_LIM     = 10'(XMAX - SIZE);
  localparam logic signed [9:0] Y_LAND    = 10'(FLOOR - SIZE);
  localparam logic signed [4:0] V_MAX     = 5'(VMAX);
  localparam logic [3:0]        GRAV_LAST = 4'(GRAV_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, ERASE_REQ, ERASE_WAIT, UPDATE, DRAW_REQ, DRAW_WAIT
  } state_t;

  state_t             state;
  logic [7:0]         x;
  logic [6:0]         y;
  logic signed [4:0]  vx, vy;
  logic [3:0]         fc;
  logic               drawn, pending;

  logic signed [9:0]  nx, ny;
  logic [7:0]         x_nxt;
  logic [6:0]         y_nxt;
  logic signed [4:0]  vx_nxt, vy_nxt;
  logic [3:0]         fc_nxt;
  logic               land;

  assign Scaleout = 6'(SIZE);

  // Next-frame physics: move, bounce off walls/ceiling, land on floor, apply gravity.
  always_comb begin
    nx     = $signed({2'b00, x}) + $signed({{5{vx[4]}}, vx});
    ny     = $signed({3'b000, y}) + $signed({{5{vy[4]}}, vy});
    x_nxt  = nx[7:0];
    vx_nxt = vx;
    y_nxt  = ny[6:0];
    vy_nxt = vy;
    fc_nxt = fc;
    land   = 1'b0;
    if (nx[9]) begin
      x_nxt  = 8'd0;
      vx_nxt = -vx;
    end else if (nx > X_LIM) begin
      x_nxt  = X_LIM[7:0];
      vx_nxt = -vx;
    end
    if (ny[9]) begin
      y_nxt  = 7'd0;
      vy_nxt = -vy;
    end else if (ny >= Y_LAND) begin
      // Landing stops all motion, including any horizontal bounce this frame.
      y_nxt  = Y_LAND[6:0];
      vx_nxt = 5'sd0;
      vy_nxt = 5'sd0;
      land   = 1'b1;
    end else if (fc == GRAV_LAST) begin
      fc_nxt = 4'd0;
      vy_nxt = (vy >= V_MAX) ? V_MAX : vy + 5'sd1;
    end else begin
      fc_nxt = fc + 4'd1;
    end
  end

  // Frame-service sequencer with registered drawer outputs and ball state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x         <= 8'(X0);
      y         <= 7'(Y0);
      vx        <= 5'sd0;
      vy        <= 5'sd0;
      fc        <= 4'd0;
      drawn     <= 1'b0;
      pending   <= 1'b0;
      Xout      <= 8'd0;
      Yout      <= 7'd0;
      CLRout    <= 3'd0;
      go        <= 1'b0;
      busy      <= 1'b0;
      in_flight <= 1'b0;
      landed    <= 1'b0;
    end else begin
      go <= 1'b0;
      if (frame_tick && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (pending || (frame_tick && in_flight)) begin
            busy    <= 1'b1;
            pending <= 1'b0;
            if (drawn) begin
              Xout   <= x;
              Yout   <= y;
              CLRout <= BG_CLR;
              go     <= 1'b1;
              state  <= ERASE_REQ;
            end else begin
              state <= UPDATE;
            end
          end else if (launch && !in_flight) begin
            vx        <= $signed(launch_vx);
            vy        <= $signed(launch_vy);
            fc        <= 4'd0;
            in_flight <= 1'b1;
            landed    <= 1'b0;
          end
        end
        ERASE_REQ:  state <= ERASE_WAIT;
        ERASE_WAIT: if (box_done) state <= UPDATE;
        UPDATE: begin
          x      <= x_nxt;
          y      <= y_nxt;
          vx     <= vx_nxt;
          vy     <= vy_nxt;
          fc     <= fc_nxt;
          if (land) begin
            in_flight <= 1'b0;
            landed    <= 1'b1;
          end
          Xout   <= x_nxt;
          Yout   <= y_nxt;
          CLRout <= BALL_CLR;
          go     <= 1'b1;
          state  <= DRAW_REQ;
        end
        DRAW_REQ:   state <= DRAW_WAIT;
        DRAW_WAIT: begin
          if (box_done) begin
            drawn <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default:    state <= IDLE;
      endcase
    end
  end

endmodule
